// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared types and defaults for the gated multi-channel oscillator
package ring_osc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int CHANNELS_DEF = 4;
   localparam int CNT_W_DEF    = 8;
   localparam int TOG_W_DEF    = 16;
   localparam int HP_RESET_DEF = 4;

   localparam int SEL_W   = $clog2(CHANNELS_DEF);
   localparam int TOG_MAX = (1 << TOG_W_DEF) - 1;

endpackage

// File: rtl/ring_osc_chan.sv
// rtl/ring_osc_chan.sv - one oscillator channel: run/stop FSM, phase counter, saturating rise counter
module ring_osc_chan
   import ring_osc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TOG_W = TOG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [CNT_W-1:0] hp,
   input  logic             clr,
   output logic             q,
   output logic             busy,
   output logic [TOG_W-1:0] edges
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] phase, phase_nx;
   logic             q_nx;
   logic [TOG_W-1:0] edges_nx;
   logic             rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         phase <= '0;
         q     <= 1'b0;
         edges <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         q     <= q_nx;
         edges <= edges_nx;
      end
   end

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      q_nx     = q;
      case (state)
         IDLE: begin
            q_nx = 1'b0;
            if (run) begin
               state_nx = RUN;
               phase_nx = hp;
            end
         end
         RUN, STOPPING: begin
            if (!run && !q) begin
               state_nx = IDLE;
               phase_nx = '0;
            end else begin
               // A high phase always runs to completion, even with run low.
               state_nx = run ? RUN : STOPPING;
               if (phase == '0) begin
                  q_nx     = ~q;
                  phase_nx = hp;
                  if (q && !run) begin
                     state_nx = IDLE;
                     phase_nx = '0;
                  end
               end else begin
                  phase_nx = phase - 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            phase_nx = '0;
            q_nx     = 1'b0;
         end
      endcase
   end

   assign rise = q_nx & ~q;
   assign busy = (state != IDLE);

   always_comb begin
      edges_nx = edges;
      if (clr) begin
         edges_nx = '0;
      end else if (rise && (edges != {TOG_W{1'b1}})) begin
         edges_nx = edges + 1'b1;
      end
   end

endmodule

// File: rtl/ring_osc_gen.sv
// rtl/ring_osc_gen.sv - gated multi-channel square-wave source with shared half-period and count readout
module ring_osc_gen
   import ring_osc_pkg::*;
#(
   parameter int CHANNELS = CHANNELS_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int TOG_W    = TOG_W_DEF,
   parameter int HP_RESET = HP_RESET_DEF
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [CHANNELS-1:0]         A1,
   input  logic [CHANNELS-1:0]         A2,
   input  logic [CNT_W-1:0]            HP,
   input  logic                        LOAD,
   input  logic                        CLR_CNT,
   input  logic [$clog2(CHANNELS)-1:0] SEL,
   output logic [CHANNELS-1:0]         Q,
   output logic [CHANNELS-1:0]         BUSY,
   output logic [TOG_W-1:0]            TOG_CNT
);

   logic [CNT_W-1:0] shadow_hp;
   logic [TOG_W-1:0] edges [CHANNELS];

   always_ff @(posedge CLK) begin
      if (RST) begin
         shadow_hp <= CNT_W'(HP_RESET);
         TOG_CNT   <= '0;
      end else begin
         if (LOAD) begin
            shadow_hp <= HP;
         end
         TOG_CNT <= (int'(SEL) < CHANNELS) ? edges[SEL] : '0;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      ring_osc_chan #(
         .CNT_W(CNT_W),
         .TOG_W(TOG_W)
      ) u_chan (
         .clk  (CLK),
         .rst  (RST),
         .run  (A1[i] & A2[i]),
         .hp   (shadow_hp),
         .clr  (CLR_CNT),
         .q    (Q[i]),
         .busy (BUSY[i]),
         .edges(edges[i])
      );
   end

endmodule

// File: tb/tb_ring_osc_gen.sv
// tb/tb_ring_osc_gen.sv - directed and randomized checks of ring_osc_gen against a timestamp model
module tb_ring_osc_gen;

   localparam int CH    = 4;
   localparam int CW    = 8;
   localparam int TW    = 4;
   localparam int HPR   = 4;
   localparam int TMAX  = (1 << TW) - 1;

   logic          clk;
   logic          rst;
   logic [CH-1:0] a1, a2;
   logic [CW-1:0] hp;
   logic          load, clr;
   logic [1:0]    sel;
   logic [CH-1:0] q, busy;
   logic [TW-1:0] tog;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   // model: a running channel toggles at absolute cycle numbers
   int ncyc = 0;
   int m_sh;
   bit m_on  [CH];
   bit m_q   [CH];
   int m_next[CH];
   int m_cnt [CH];
   int m_tog;

   ring_osc_gen #(
      .CHANNELS(CH),
      .CNT_W   (CW),
      .TOG_W   (TW),
      .HP_RESET(HPR)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .A1     (a1),
      .A2     (a2),
      .HP     (hp),
      .LOAD   (load),
      .CLR_CNT(clr),
      .SEL    (sel),
      .Q      (q),
      .BUSY   (busy),
      .TOG_CNT(tog)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_sh  = HPR;
         m_tog = 0;
         for (int i = 0; i < CH; i++) begin
            m_on[i] = 0; m_q[i] = 0; m_next[i] = 0; m_cnt[i] = 0;
         end
      end else begin
         m_tog = (int'(sel) < CH) ? m_cnt[sel] : 0;
         for (int i = 0; i < CH; i++) begin
            bit run, rise;
            run  = a1[i] & a2[i];
            rise = 0;
            if (!m_on[i]) begin
               if (run) begin
                  m_on[i]   = 1;
                  m_next[i] = ncyc + m_sh + 1;
               end
            end else if (!run && !m_q[i]) begin
               m_on[i] = 0;
            end else if (ncyc == m_next[i]) begin
               m_q[i]    = !m_q[i];
               rise      = m_q[i];
               m_next[i] = ncyc + m_sh + 1;
               if (!m_q[i] && !run) m_on[i] = 0;
            end
            if (clr) m_cnt[i] = 0;
            else if (rise && m_cnt[i] < TMAX) m_cnt[i] = m_cnt[i] + 1;
         end
         if (load) m_sh = int'(hp);
      end
      ncyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < CH; i++) begin
            check($sformatf("q[%0d]", i), int'(q[i]), int'(m_q[i]));
            check($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_on[i]));
         end
         check("tog_cnt", int'(tog), m_tog);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; a1 = '0; a2 = '0; load = 0; clr = 0;
      tick(1);
      rst = 0;
   endtask

   task automatic load_hp(input int v);
      hp = CW'(v); load = 1;
      tick(1);
      load = 0;
   endtask

   task automatic wait_rise(input int ch, output int k);
      k = 0;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         if (q[ch]) begin
            k = j;
            break;
         end
      end
   endtask

   initial begin
      int k, hi, lo;
      rst = 1; a1 = '0; a2 = '0; hp = '0; load = 0; clr = 0; sel = '0;
      tick(1);
      chk_en = 1;

      // reset state; LOAD under reset must not disturb the reset half-period
      rst = 1; hp = 8'hFF; load = 1;
      tick(1);
      rst = 0; load = 0;
      tick(20);
      check("t1_q", int'(q), 0);
      check("t1_busy", int'(busy), 0);
      check("t1_tog", int'(tog), 0);
      a1[0] = 1; a2[0] = 1;
      wait_rise(0, k);
      check("t1_first_rise_hp4", k, 6);

      // HP=3: rise on edge e0+4, then 8-cycle period
      do_reset();
      load_hp(3);
      sel = 0;
      a1[0] = 1; a2[0] = 1;
      wait_rise(0, k);
      check("t2_first_rise_hp3", k, 5);
      hi = 1;
      tick(1);
      while (q[0] && hi < 20) begin hi++; tick(1); end
      check("t2_high_len", hi, 4);
      tick(80 - k - hi);
      check("t2_tog_80", int'(tog), 10);

      // enable pattern, HP=1: every high pulse exactly 2 cycles
      do_reset();
      load_hp(1);
      hi = 0;
      for (int p = 0; p < 7; p++) begin
         bit [1:0] pat;
         case (p)
            0: pat = 2'b00; 1: pat = 2'b11; 2: pat = 2'b10; 3: pat = 2'b11;
            4: pat = 2'b00; 5: pat = 2'b11; default: pat = 2'b00;
         endcase
         a1[0] = pat[1]; a2[0] = pat[0];
         for (int c = 0; c < 10; c++) begin
            tick(1);
            if (q[0]) hi++;
            else if (hi > 0) begin check("t3_pulse_len", hi, 2); hi = 0; end
         end
      end

      // stop one cycle into a high phase, HP=5
      do_reset();
      load_hp(5);
      a1[1] = 1; a2[1] = 1;
      wait_rise(1, k);
      check("t4_first_rise_hp5", k, 7);
      hi = 1;
      tick(1); hi++;
      a2[1] = 0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (q[1]) hi++; else break;
      end
      check("t4_stop_high_len", hi, 6);
      check("t4_busy_after_stop", int'(busy[1]), 0);
      // reassert while STOPPING: phase keeps counting
      a2[1] = 1;
      wait_rise(1, k);
      hi = 1;
      tick(1); hi++;
      a2[1] = 0;
      tick(2); hi += 2;
      a2[1] = 1;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (q[1]) hi++; else break;
      end
      check("t4_resume_high_len", hi, 6);
      lo = 1;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (!q[1]) lo++; else break;
      end
      check("t4_resume_low_len", lo, 6);

      // HP=0 on ch2: saturation at 15, clear beats a coincident rise
      do_reset();
      load_hp(0);
      sel = 2;
      a1[2] = 1; a2[2] = 1;
      tick(40);
      check("t5_saturated", int'(tog), 15);
      if (q[2]) tick(1);
      check("t5_q_low_before_clr", int'(q[2]), 0);
      clr = 1;
      tick(1);
      clr = 0;
      tick(1);
      check("t5_clr_wins", int'(tog), 0);

      // reset while ch3 is high
      do_reset();
      load_hp(5);
      sel = 3;
      a1[3] = 1; a2[3] = 1;
      wait_rise(3, k);
      tick(2);
      check("t6_tog_before_rst", int'(tog), 1);
      check("t6_q_high", int'(q[3]), 1);
      rst = 1;
      tick(1);
      check("t6_q_after_rst", int'(q[3]), 0);
      check("t6_busy_after_rst", int'(busy[3]), 0);
      check("t6_tog_after_rst", int'(tog), 0);
      rst = 0; a1 = '0; a2 = '0;

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int idx;
         tick(1);
         if ($urandom_range(0, 7) == 0) begin idx = $urandom_range(0, CH-1); a1[idx] = ~a1[idx]; end
         if ($urandom_range(0, 7) == 0) begin idx = $urandom_range(0, CH-1); a2[idx] = ~a2[idx]; end
         load = ($urandom_range(0, 24) == 0);
         hp   = CW'($urandom_range(0, 6));
         clr  = ($urandom_range(0, 149) == 0);
         sel  = 2'($urandom_range(0, CH-1));
         rst  = ($urandom_range(0, 799) == 0);
      end
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
